// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU select and width definitions for the CPU slice
package cpu_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int OP_W_DEF   = 3;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_XOR   = 3'b100,
    OP_BNE   = 3'b101,
    OP_HALT  = 3'b111
  } opcode_e;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_XOR  = 2'b11;

  // Instructions that take a memory operand and therefore need an EXEC cycle.
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) ||
           (op == OP_SUB)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/sequencer.sv
// rtl/sequencer.sv - Moore control sequencer: fetch, decode and execute strobes for the accumulator CPU
module sequencer
  import cpu_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic            run,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  output logic            PC_bus,
  output logic            Addr_bus,
  output logic            MDR_bus,
  output logic            ACC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_IR,
  output logic            load_MAR,
  output logic            load_MDR,
  output logic            load_ACC,
  output logic [1:0]      alu_op,
  output logic            CS,
  output logic            R_NW,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_FETCH0 = 3'd0,
    S_FETCH1 = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  if (OP_W > WORD_W) begin : g_width_check
    $error("opcode field wider than bus word");
  end

  state_e          r_state;
  state_e          w_state_next;
  logic [OP_W-1:0] r_op;
  logic [2:0]      w_dec_op;
  logic [2:0]      w_exec_op;

  // DECODE acts on the live IR opcode; EXEC only ever sees the latched copy.
  assign w_dec_op  = 3'(op);
  assign w_exec_op = 3'(r_op);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_FETCH0;
      r_op    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE) r_op <= op;
    end
  end

  always_comb begin
    w_state_next = r_state;
    PC_bus   = 1'b0;
    Addr_bus = 1'b0;
    MDR_bus  = 1'b0;
    ACC_bus  = 1'b0;
    load_PC  = 1'b0;
    INC_PC   = 1'b0;
    load_IR  = 1'b0;
    load_MAR = 1'b0;
    load_MDR = 1'b0;
    load_ACC = 1'b0;
    alu_op   = ALU_PASS;
    CS       = 1'b0;
    R_NW     = 1'b0;
    halted   = 1'b0;

    case (r_state)
      S_FETCH0: begin
        if (run) begin
          PC_bus       = 1'b1;
          load_MAR     = 1'b1;
          INC_PC       = 1'b1;
          w_state_next = S_FETCH1;
        end
      end
      S_FETCH1: begin
        CS           = 1'b1;
        R_NW         = 1'b1;
        MDR_bus      = 1'b1;
        load_IR      = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        w_state_next = S_FETCH0;
        if (is_mem_op(w_dec_op)) begin
          Addr_bus     = 1'b1;
          load_MAR     = 1'b1;
          w_state_next = S_EXEC;
        end else if (w_dec_op == OP_BNE) begin
          if (!z_flag) begin
            Addr_bus = 1'b1;
            load_PC  = 1'b1;
          end
        end else if (w_dec_op == OP_HALT) begin
          w_state_next = S_HALT;
        end
      end
      S_EXEC: begin
        w_state_next = S_FETCH0;
        CS           = 1'b1;
        if (w_exec_op == OP_STORE) begin
          ACC_bus  = 1'b1;
          load_MDR = 1'b1;
        end else begin
          R_NW     = 1'b1;
          MDR_bus  = 1'b1;
          load_ACC = 1'b1;
          case (w_exec_op)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_XOR:  alu_op = ALU_XOR;
            default: alu_op = ALU_PASS;
          endcase
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_state_next = S_FETCH0;
    endcase

    // Outputs drop the instant reset asserts, even with run high in FETCH0.
    if (!n_reset) begin
      PC_bus   = 1'b0;
      Addr_bus = 1'b0;
      MDR_bus  = 1'b0;
      ACC_bus  = 1'b0;
      load_PC  = 1'b0;
      INC_PC   = 1'b0;
      load_IR  = 1'b0;
      load_MAR = 1'b0;
      load_MDR = 1'b0;
      load_ACC = 1'b0;
      alu_op   = ALU_PASS;
      CS       = 1'b0;
      R_NW     = 1'b0;
      halted   = 1'b0;
    end
  end

endmodule

// File: tb/tb_sequencer.sv
// tb/tb_sequencer.sv - table-driven and directed checks for the sequencer
module tb_sequencer;

  logic       clock;
  logic       n_reset;
  logic       run;
  logic [2:0] op;
  logic       z_flag;
  logic       PC_bus, Addr_bus, MDR_bus, ACC_bus;
  logic       load_PC, INC_PC, load_IR, load_MAR, load_MDR, load_ACC;
  logic [1:0] alu_op;
  logic       CS, R_NW, halted;

  sequencer #(.WORD_W(8), .OP_W(3)) dut (
    .clock(clock), .n_reset(n_reset), .run(run), .op(op), .z_flag(z_flag),
    .PC_bus(PC_bus), .Addr_bus(Addr_bus), .MDR_bus(MDR_bus), .ACC_bus(ACC_bus),
    .load_PC(load_PC), .INC_PC(INC_PC), .load_IR(load_IR), .load_MAR(load_MAR),
    .load_MDR(load_MDR), .load_ACC(load_ACC), .alu_op(alu_op),
    .CS(CS), .R_NW(R_NW), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [14:0] PCB  = 15'h4000;
  localparam logic [14:0] ADB  = 15'h2000;
  localparam logic [14:0] MDB  = 15'h1000;
  localparam logic [14:0] ACB  = 15'h0800;
  localparam logic [14:0] LPC  = 15'h0400;
  localparam logic [14:0] IPC  = 15'h0200;
  localparam logic [14:0] LIR  = 15'h0100;
  localparam logic [14:0] LMAR = 15'h0080;
  localparam logic [14:0] LMDR = 15'h0040;
  localparam logic [14:0] LACC = 15'h0020;
  localparam logic [14:0] AADD = 15'h0008;
  localparam logic [14:0] ASUB = 15'h0010;
  localparam logic [14:0] AXOR = 15'h0018;
  localparam logic [14:0] CSB  = 15'h0004;
  localparam logic [14:0] RNW  = 15'h0002;
  localparam logic [14:0] HLT  = 15'h0001;

  localparam logic [14:0] E_F0   = PCB | LMAR | IPC;
  localparam logic [14:0] E_F1   = CSB | RNW | MDB | LIR;
  localparam logic [14:0] E_DMEM = ADB | LMAR;
  localparam logic [14:0] E_BNE  = ADB | LPC;
  localparam logic [14:0] E_RD   = CSB | RNW | MDB | LACC;
  localparam logic [14:0] E_ST   = CSB | ACB | LMDR;

  logic [14:0] outs;
  assign outs = {PC_bus, Addr_bus, MDR_bus, ACC_bus, load_PC, INC_PC, load_IR,
                 load_MAR, load_MDR, load_ACC, alu_op, CS, R_NW, halted};

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        run;
    logic [2:0]  op;
    logic        z;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic r, input logic [2:0] o,
                     input logic z, input logic [14:0] e);
    vec_t v;
    v.name = name; v.run = r; v.op = o; v.z = z; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called mid-cycle: drive, settle, compare, then advance one clock.
  task automatic step(input string name, input logic r, input logic [2:0] o,
                      input logic z, input logic [14:0] e);
    run = r; op = o; z_flag = z;
    #1;
    check(name, outs, e);
    checks++;
    if ($countones(outs[14:11]) > 1 || (!outs[5] && outs[4:3] != 2'b00)) begin
      errors++;
      $display("FAIL %s_invariant: got %h expected one bus and alu_op 00 unless load_ACC", name, outs);
    end
    @(posedge clock);
    #2;
  endtask

  function automatic logic [14:0] dec_exp(input logic [2:0] o, input logic z);
    case (o)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: return E_DMEM;
      3'd5:    return z ? 15'h0 : E_BNE;
      default: return 15'h0;
    endcase
  endfunction

  function automatic logic [14:0] exec_exp(input logic [2:0] o);
    case (o)
      3'd1:    return E_ST;
      3'd2:    return E_RD | AADD;
      3'd3:    return E_RD | ASUB;
      3'd4:    return E_RD | AXOR;
      default: return E_RD;
    endcase
  endfunction

  initial begin
    n_reset = 1'b0; run = 1'b1; op = 3'd0; z_flag = 1'b0;

    // Memory-operand instructions; op is scrambled outside DECODE on purpose.
    add("load_f0", 1, 3'd7, 0, E_F0);  add("load_f1", 1, 3'd3, 0, E_F1);
    add("load_dec", 1, 3'd0, 0, E_DMEM); add("load_ex", 1, 3'd7, 0, E_RD);
    add("store_f0", 1, 3'd0, 0, E_F0); add("store_f1", 1, 3'd0, 0, E_F1);
    add("store_dec", 1, 3'd1, 0, E_DMEM); add("store_ex", 1, 3'd2, 0, E_ST);
    add("add_f0", 1, 3'd0, 0, E_F0);   add("add_f1", 1, 3'd0, 0, E_F1);
    add("add_dec", 1, 3'd2, 1, E_DMEM); add("add_ex", 1, 3'd1, 0, E_RD | AADD);
    add("sub_f0", 1, 3'd0, 0, E_F0);   add("sub_f1", 1, 3'd0, 0, E_F1);
    add("sub_dec", 1, 3'd3, 0, E_DMEM); add("sub_ex", 1, 3'd0, 0, E_RD | ASUB);
    add("xor_f0", 1, 3'd0, 0, E_F0);   add("xor_f1", 1, 3'd0, 0, E_F1);
    add("xor_dec", 1, 3'd4, 0, E_DMEM); add("xor_ex", 1, 3'd5, 0, E_RD | AXOR);
    // Three-cycle instructions.
    add("bne0_f0", 1, 3'd0, 0, E_F0);  add("bne0_f1", 1, 3'd0, 0, E_F1);
    add("bne0_dec", 1, 3'd5, 0, E_BNE);
    add("bne1_f0", 1, 3'd0, 1, E_F0);  add("bne1_f1", 1, 3'd0, 1, E_F1);
    add("bne1_dec", 1, 3'd5, 1, 15'h0);
    add("nop_f0", 1, 3'd0, 0, E_F0);   add("nop_f1", 1, 3'd0, 0, E_F1);
    add("nop_dec", 1, 3'd6, 0, 15'h0);
    for (int i = 0; i < 5; i++) add("run0_idle", 0, 3'd7, 0, 15'h0);
    // run only matters in FETCH0.
    add("runig_f0", 1, 3'd0, 0, E_F0); add("runig_f1", 0, 3'd0, 0, E_F1);
    add("runig_dec", 0, 3'd0, 1, E_DMEM); add("runig_ex", 0, 3'd0, 0, E_RD);
    add("halt_f0", 1, 3'd0, 0, E_F0);  add("halt_f1", 1, 3'd0, 0, E_F1);
    add("halt_dec", 1, 3'd7, 0, 15'h0);
    for (int i = 0; i < 20; i++) add("halted", 1, 3'(i), 0, HLT);

    #12;
    check("reset_outs", outs, 15'h0);
    @(negedge clock);
    n_reset = 1'b1;

    foreach (vecs[i]) step(vecs[i].name, vecs[i].run, vecs[i].op, vecs[i].z, vecs[i].exp);

    n_reset = 1'b0;
    #1 check("halt_reset_outs", outs, 15'h0);
    #1 n_reset = 1'b1;
    #1 check("halt_reset_fetch", outs, E_F0);
    @(posedge clock); #2;
    step("post_halt_f1", 1, 3'd0, 0, E_F1);
    step("post_halt_dec", 1, 3'd6, 0, 15'h0);

    // Reset landing in the EXEC of a STORE aborts it immediately.
    step("abort_f0", 1, 3'd0, 0, E_F0);
    step("abort_f1", 1, 3'd0, 0, E_F1);
    step("abort_dec", 1, 3'd1, 0, E_DMEM);
    #1 check("abort_ex", outs, E_ST);
    n_reset = 1'b0;
    #1 check("abort_outs", outs, 15'h0);
    @(posedge clock); #2;
    check("abort_held", outs, 15'h0);
    n_reset = 1'b1;
    #1 check("abort_refetch", outs, E_F0);
    @(posedge clock); #2;
    step("abort_refetch_f1", 1, 3'd0, 0, E_F1);
    step("abort_nop", 1, 3'd6, 0, 15'h0);

    for (int n = 0; n < 1000; n++) begin
      logic [2:0] ro;
      logic       rz;
      ro = 3'($urandom_range(0, 6));
      rz = 1'($urandom_range(0, 1));
      step("rnd_f0", 1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), E_F0);
      step("rnd_f1", 1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), E_F1);
      step("rnd_dec", 1, ro, rz, dec_exp(ro, rz));
      if (ro <= 3'd4)
        step("rnd_ex", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), exec_exp(ro));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
